eagle_host_sequencer: RTL and testbench

- Initiator-side master for the Keccak-f[400] accelerator's word-addressed BRAM port (CPU side).
- Replaces software polling. It loads a 400-bit state, writes the start code to the control register, polls until the done code appears, reads the result back, then clears the control register.
- Sits between a local hashing datapath and the accelerator's 32-bit read/write port.

---
 rtl/eagle_host_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_eagle_host_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eagle_host_sequencer.sv
// Host-side sequencer for the Keccak-f[400] accelerator BRAM port: load state, start, poll, read back, clear.
// Optional poll timeout is compiled in with `define EAGLE_HOST_TIMEOUT_EN.
module eagle_host_sequencer #(
    parameter logic [7:0] START_CODE     = 8'hAA,
    parameter logic [7:0] DONE_CODE      = 8'h55,
    parameter logic [3:0] CTRL_ADDR      = 4'hF,
    parameter int         POLL_GAP       = 4
`ifdef EAGLE_HOST_TIMEOUT_EN
    ,parameter int        TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [399:0] i_v_state,
    output logic         o_busy,
    output logic         o_done,
    output logic [399:0] o_v_state,
`ifdef EAGLE_HOST_TIMEOUT_EN
    output logic         o_timeout,
`endif
    output logic         o_a_wr,
    output logic         o_a_en_rd,
    output logic [3:0]   o_v_a_addr,
    output logic [31:0]  o_v_a_din,
    output logic [3:0]   o_v_S_AXI_WSTRB,
    input  logic [31:0]  i_v_a_dout
);

    localparam int GAP_W = (POLL_GAP == 0) ? 1 : $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WRITE, ST_START, ST_POLL_REQ, ST_POLL_CHK,
        ST_POLL_WAIT, ST_READ, ST_CLEAR, ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [399:0]       data_reg;
    logic [399:0]       result_reg;
    logic [31:0]        wr_word [13];
    logic               in_poll;
    logic               hit;
    logic               timed_out;

    // The same register holds the outgoing state and, later, the words read back.
    for (genvar gi = 0; gi < 12; gi++) begin : g_words
        assign wr_word[gi] = data_reg[32*gi +: 32];
    end
    assign wr_word[12] = {16'h0, data_reg[399:384]};

    assign in_poll   = (state_reg == ST_POLL_REQ) || (state_reg == ST_POLL_CHK) ||
                       (state_reg == ST_POLL_WAIT);
    assign hit       = (state_reg == ST_POLL_CHK) && (i_v_a_dout[7:0] == DONE_CODE);
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_v_state = result_reg;

`ifdef EAGLE_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_reg;
    logic            to_expired;

    assign to_expired = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign timed_out  = timeout_reg;
    assign o_timeout  = timeout_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_START)
                to_cnt_reg <= '0;
            else if (in_poll && !to_expired)
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            if (state_reg == ST_IDLE && i_start)
                timeout_reg <= 1'b0;
            else if (in_poll && state_next == ST_CLEAR)
                timeout_reg <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            gap_reg    <= '0;
            data_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            if (state_reg == ST_IDLE && i_start)
                data_reg <= i_v_state;
            // Read data lags the request by one cycle, so cycle n captures word n-1.
            if (state_reg == ST_READ) begin
                for (int k = 0; k < 12; k++)
                    if (cnt_reg == 4'(k + 1))
                        data_reg[32*k +: 32] <= i_v_a_dout;
                if (cnt_reg == 4'd13)
                    data_reg[399:384] <= i_v_a_dout[15:0];
            end
            if (state_reg == ST_CLEAR && !timed_out)
                result_reg <= data_reg;
        end
    end

    always_comb begin
        state_next      = state_reg;
        o_a_wr          = 1'b0;
        o_a_en_rd       = 1'b0;
        o_v_a_addr      = 4'h0;
        o_v_a_din       = 32'h0;
        o_v_S_AXI_WSTRB = 4'h0;
        o_done          = 1'b0;
        case (state_reg)
            ST_IDLE: if (i_start) state_next = ST_WRITE;
            ST_WRITE: begin
                o_a_wr          = 1'b1;
                o_v_a_addr      = cnt_reg;
                o_v_a_din       = wr_word[cnt_reg];
                o_v_S_AXI_WSTRB = (cnt_reg == 4'd12) ? 4'h3 : 4'hF;
                if (cnt_reg == 4'd12) state_next = ST_START;
            end
            ST_START: begin
                o_a_wr          = 1'b1;
                o_v_a_addr      = CTRL_ADDR;
                o_v_a_din       = {24'h0, START_CODE};
                o_v_S_AXI_WSTRB = 4'h1;
                state_next      = ST_POLL_REQ;
            end
            ST_POLL_REQ: begin
                o_a_en_rd  = 1'b1;
                o_v_a_addr = CTRL_ADDR;
                state_next = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (hit)                state_next = ST_READ;
                else if (POLL_GAP == 0) state_next = ST_POLL_REQ;
                else                    state_next = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: if (gap_reg == GAP_W'(POLL_GAP - 1)) state_next = ST_POLL_REQ;
            ST_READ: begin
                if (cnt_reg != 4'd13) begin
                    o_a_en_rd  = 1'b1;
                    o_v_a_addr = cnt_reg;
                end else begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_a_wr          = 1'b1;
                o_v_a_addr      = CTRL_ADDR;
                o_v_S_AXI_WSTRB = 4'h1;
                state_next      = ST_DONE;
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef EAGLE_HOST_TIMEOUT_EN
        if (in_poll && !hit && to_expired) state_next = ST_CLEAR;
`endif
    end

    always_comb begin
        cnt_next = 4'h0;
        gap_next = '0;
        if ((state_reg == ST_WRITE || state_reg == ST_READ) && state_next == state_reg)
            cnt_next = cnt_reg + 4'd1;
        if (state_reg == ST_POLL_WAIT && state_next == ST_POLL_WAIT)
            gap_next = gap_reg + GAP_W'(1);
    end

endmodule

// File: tb/tb_eagle_host_sequencer.sv
// Scoreboard bench for eagle_host_sequencer: a BRAM/accelerator model plus expected bus-event queue.
module tb_eagle_host_sequencer;
    localparam logic [3:0] CTRL = 4'hF;
    localparam int         GAP  = 4;

    logic         i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
    logic [399:0] i_v_state = '0;
    logic         o_busy, o_done, o_a_wr, o_a_en_rd;
    logic [399:0] o_v_state;
    logic [3:0]   o_v_a_addr, o_v_S_AXI_WSTRB;
    logic [31:0]  o_v_a_din;
    logic [31:0]  i_v_a_dout = '0;
`ifdef EAGLE_HOST_TIMEOUT_EN
    logic         o_timeout;
`endif

    eagle_host_sequencer #(
        .POLL_GAP(GAP)
`ifdef EAGLE_HOST_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_v_state(i_v_state),
        .o_busy(o_busy), .o_done(o_done), .o_v_state(o_v_state),
`ifdef EAGLE_HOST_TIMEOUT_EN
        .o_timeout(o_timeout),
`endif
        .o_a_wr(o_a_wr), .o_a_en_rd(o_a_en_rd), .o_v_a_addr(o_v_a_addr),
        .o_v_a_din(o_v_a_din), .o_v_S_AXI_WSTRB(o_v_S_AXI_WSTRB), .i_v_a_dout(i_v_a_dout)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Accelerator model: after the start code, waits model_delay cycles, scrambles words 0..12 and posts DONE.
    logic [31:0] mem [16];
    int          model_delay = 0, model_cnt = 0;
    logic        start_wr, fire;

    function automatic logic [31:0] mask(input int k);
        return 32'hC3A5_5A3C ^ (32'(k) * 32'h0107_0301);
    endfunction

    assign start_wr = o_a_wr && o_v_a_addr == CTRL && o_v_S_AXI_WSTRB[0] && o_v_a_din[7:0] == 8'hAA;
    assign fire     = (model_cnt == 1) || (start_wr && model_delay == 0);

    initial for (int k = 0; k < 16; k++) mem[k] = '0;

    always @(posedge i_clk) begin
        if (o_a_en_rd) i_v_a_dout <= mem[o_v_a_addr];
        if (model_cnt > 0) model_cnt <= model_cnt - 1;
        if (o_a_wr) begin
            for (int b = 0; b < 4; b++)
                if (o_v_S_AXI_WSTRB[b]) mem[o_v_a_addr][8*b +: 8] <= o_v_a_din[8*b +: 8];
            if (start_wr && model_delay > 0) model_cnt <= model_delay;
        end
        if (fire) begin
            for (int k = 0; k < 13; k++) mem[k] <= mem[k] ^ mask(k);
            mem[CTRL][7:0] <= 8'h55;
        end
    end

    // kind: 0 = write, 1 = read, 2 = done pulse
    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [3:0]  strb;
        logic [399:0] st;
        logic        to;
    } ev_t;
    ev_t          exp_q[$];
    ev_t          mon_e;
    logic [399:0] last_res = '0;

    task automatic push_txn(input logic [399:0] st, input int c0, input int misses, input bit to);
        ev_t e; logic [31:0] m; int base, npoll;
        e.st = '0; e.to = 1'b0;
        for (int k = 0; k < 13; k++) begin
            e.kind = 0; e.cyc = c0 + 1 + k; e.addr = 4'(k);
            if (k < 12) begin e.din = st[32*k +: 32]; e.strb = 4'hF; end
            else begin e.din = {16'h0, st[399:384]}; e.strb = 4'h3; end
            exp_q.push_back(e);
        end
        e.kind = 0; e.cyc = c0 + 14; e.addr = CTRL; e.din = 32'hAA; e.strb = 4'h1;
        exp_q.push_back(e);
        npoll = to ? 11 : misses + 1;
        for (int i = 0; i < npoll; i++) begin
            e.kind = 1; e.cyc = c0 + 15 + i * (2 + GAP); e.addr = CTRL; e.din = '0; e.strb = '0;
            exp_q.push_back(e);
        end
        if (!to) begin
            base = c0 + 17 + misses * (2 + GAP);
            for (int k = 0; k < 13; k++) begin
                e.kind = 1; e.cyc = base + k; e.addr = 4'(k);
                exp_q.push_back(e);
            end
            for (int k = 0; k < 12; k++) last_res[32*k +: 32] = st[32*k +: 32] ^ mask(k);
            m = mask(12);
            last_res[399:384] = st[399:384] ^ m[15:0];
        end else begin
            base = c0 + 65;
        end
        e.kind = 0; e.cyc = base + 14; e.addr = CTRL; e.din = 32'h0; e.strb = 4'h1;
        exp_q.push_back(e);
        e.kind = 2; e.cyc = base + 15; e.st = last_res; e.to = to;
        exp_q.push_back(e);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_a_wr && o_a_en_rd) begin
                checks++; failures++;
                $display("FAIL bus_exclusive cyc=%0d wr=1 rd=1 required not both", cyc);
            end
            if (o_a_wr || o_a_en_rd || o_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d wr=%0b rd=%0b done=%0b addr=%h required no activity",
                             cyc, o_a_wr, o_a_en_rd, o_done, o_v_a_addr);
                end else begin
                    int  ak;
                    bit  ok;
                    mon_e = exp_q.pop_front();
                    ak = o_a_wr ? 0 : (o_a_en_rd ? 1 : 2);
                    ok = (ak == mon_e.kind) && (cyc == mon_e.cyc);
                    if (ak < 2 && o_v_a_addr != mon_e.addr) ok = 0;
                    if (ak == 0 && (o_v_a_din != mon_e.din || o_v_S_AXI_WSTRB != mon_e.strb)) ok = 0;
                    if (ak == 2 && (o_v_state != mon_e.st || !o_busy)) ok = 0;
`ifdef EAGLE_HOST_TIMEOUT_EN
                    if (ak == 2 && o_timeout != mon_e.to) ok = 0;
`endif
                    if (!ok) begin
                        failures++;
                        $display("FAIL bus_event got cyc=%0d kind=%0d addr=%h din=%h strb=%h busy=%0b required cyc=%0d kind=%0d addr=%h din=%h strb=%h",
                                 cyc, ak, o_v_a_addr, o_v_a_din, o_v_S_AXI_WSTRB, o_busy,
                                 mon_e.cyc, mon_e.kind, mon_e.addr, mon_e.din, mon_e.strb);
                        if (ak == 2)
                            $display("FAIL done_state got %h required %h", o_v_state, mon_e.st);
                    end else begin
                        $display("ok cyc=%0d kind=%0d addr=%h din=%h", cyc, ak, o_v_a_addr, o_v_a_din);
                    end
                end
            end
        end
    end

    task automatic check_idle(input string name);
        logic [48:0] got;
        got = {o_a_wr, o_a_en_rd, o_busy, o_done, o_v_a_addr, o_v_a_din, o_v_S_AXI_WSTRB, 1'b0};
`ifdef EAGLE_HOST_TIMEOUT_EN
        got[0] = o_timeout;
`endif
        checks++;
        if (got != '0 || o_v_state != '0) begin
            failures++;
            $display("FAIL %s got ctl=%h state_nonzero=%0b required all zero", name, got, o_v_state != '0);
        end else $display("ok %s", name);
    endtask

    task automatic issue(input logic [399:0] st, input int misses, input int delay,
                         input bit to, output int c0);
        @(posedge i_clk); #1;
        model_delay = delay;
        i_start = 1'b1; i_v_state = st; c0 = cyc;
        push_txn(st, c0, misses, to);
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge i_clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge i_clk); #1;
        checks++;
        if (o_busy || o_v_state != last_res) begin
            failures++;
            $display("FAIL %s_hold busy=%0b state_match=%0b required busy=0 state_match=1",
                     name, o_busy, o_v_state == last_res);
        end else $display("ok %s_hold", name);
    endtask

    initial begin
        logic [399:0] st_a, st_b;
        int c0;
        for (int b = 0; b < 50; b++) st_a[8*b +: 8] = 8'(b + 1);
        for (int w = 0; w < 13; w++) st_b[32*w +: 32] = 32'h1357_9BDF ^ (32'(w) << 4) ^ 32'hF00D_0000;

        repeat (3) @(posedge i_clk); #1;
        check_idle("reset_state");
        i_rst = 1'b0;

        // Reset while word 5 is being written.
        issue(st_a, 0, 0, 1'b0, c0);
        repeat (5) @(posedge i_clk); #1;
        i_rst = 1'b1; #1;
        check_idle("reset_mid_write");
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (20) @(posedge i_clk); #1;
        checks++;
        if (o_busy) begin failures++; $display("FAIL post_reset_busy got 1 required 0"); end

        // Accelerator finishes 30 cycles after start: 5 missed polls.
        issue(st_a, 5, 30, 1'b0, c0);
        drain("late_done");

        // Done already posted when the first poll lands.
        issue(st_b, 0, 0, 1'b0, c0);
        drain("immediate_done");

        // Three misses: polls every 2+GAP cycles.
        issue(~st_a, 3, 18, 1'b0, c0);
        drain("three_miss");

        // Extra i_start pulses and input changes while busy must be ignored.
        issue(st_a ^ st_b, 1, 6, 1'b0, c0);
        repeat (2) @(posedge i_clk); #1;
        i_start = 1'b1; i_v_state = ~st_b;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (15) @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        drain("busy_ignore");

`ifdef EAGLE_HOST_TIMEOUT_EN
        issue(st_b, 0, -1, 1'b1, c0);
        drain("timeout");
        issue(st_a, 0, 0, 1'b0, c0);
        checks++;
        if (o_timeout) begin failures++; $display("FAIL timeout_clear got 1 required 0"); end
        drain("after_timeout");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog expired required finish");
        $fatal(1);
    end
endmodule
